// File: rtl/imem_responder.sv
// imem_responder: instruction-memory end of the fetch interface.
// One fetch in flight, fixed LATENCY, valid/ready request and response.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   ce_i                fetch enable, gates acceptance only
//   req_valid_i/_ready_o, addr_i            request handshake, byte address
//   resp_valid_o/_ready_i, inst_o, err_o    response handshake, data, fault
//   ld_we_i, ld_addr_i, ld_data_i           loader write port (word index)
//   req_cnt_o           number of accepted requests (wraps)
module imem_responder #(
    parameter int unsigned          ADDR_W     = 64,
    parameter int unsigned          INST_W     = 32,
    parameter int unsigned          DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0]    BASE_ADDR  = 64'h8000_0000,
    parameter int unsigned          LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_W-1:0]     addr_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [INST_W-1:0]     inst_o,
    output logic                  err_o,
    input  logic                  ld_we_i,
    input  logic [DEPTH_LOG2-1:0] ld_addr_i,
    input  logic [INST_W-1:0]     ld_data_i,
    output logic [31:0]           req_cnt_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    // First byte address past the end of the array.
    localparam logic [ADDR_W-1:0] LIMIT =
        BASE_ADDR + (ADDR_W'(1) << (DEPTH_LOG2 + 2));

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    resp_valid_q;
    logic [INST_W-1:0]       inst_q;
    logic                    err_q;
    logic [31:0]             req_cnt_q;
    logic [INST_W-1:0]       mem_q [DEPTH];

    logic                    accept;
    logic                    fault;
    logic [DEPTH_LOG2-1:0]   idx;

    // Ready is held low during reset regardless of ce_i.
    assign req_ready_o = rst & ce_i & (state_q == S_IDLE);
    assign accept      = req_valid_i & req_ready_o;

    assign fault = (addr_i[1:0] != 2'b00)
                 | (addr_i < BASE_ADDR)
                 | (addr_i >= LIMIT);

    // Low bits of (addr - BASE) >> 2 depend only on the low address bits.
    assign idx = addr_i[DEPTH_LOG2+1:2] - BASE_ADDR[DEPTH_LOG2+1:2];

    // Array is not reset; reads above see pre-edge contents.
    always_ff @(posedge clk) begin
        if (ld_we_i) begin
            mem_q[ld_addr_i] <= ld_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            inst_q       <= '0;
            err_q        <= 1'b0;
            req_cnt_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_cnt_q <= req_cnt_q + 32'd1;
                        inst_q    <= fault ? '0 : mem_q[idx];
                        err_q     <= fault;
                        cnt_q     <= LAT_M1;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Counting down from LATENCY-1 puts the rise of
                    // resp_valid exactly LATENCY edges after acceptance.
                    if (cnt_q == 4'd0) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign inst_o       = inst_q;
    assign err_o        = err_q;
    assign req_cnt_o    = req_cnt_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized self-checking bench for imem_responder.
// Reference model is a plain word array plus address-range rules.
module tb_imem_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          LAT  = 2;
    localparam int          NW   = 4096;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        req_valid;
    logic        req_ready_o;
    logic [63:0] addr;
    logic        resp_valid_o;
    logic        resp_ready;
    logic [31:0] inst_o;
    logic        err_o;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;
    logic [31:0] req_cnt_o;

    logic [31:0] ref_mem [NW];
    bit          ref_ok  [NW];
    int          total;
    int          bad;
    logic [31:0] exp_cnt;

    imem_responder #(
        .ADDR_W(64), .INST_W(32), .DEPTH_LOG2(12),
        .BASE_ADDR(BASE), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .ce_i(ce),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .addr_i(addr), .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready), .inst_o(inst_o), .err_o(err_o),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .req_cnt_o(req_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_resp(input logic [63:0] a,
                                     output logic e_err,
                                     output logic [31:0] e_inst);
        logic [63:0] w;
        if ((a % 4) != 0 || a < BASE || a >= BASE + 4 * NW) begin
            e_err  = 1'b1;
            e_inst = 32'h0;
        end else begin
            w      = (a - BASE) / 4;
            e_err  = 1'b0;
            e_inst = ref_mem[w];
        end
    endfunction

    task automatic load(input int idx, input logic [31:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = 12'(idx); ld_data = d;
        @(posedge clk); #1;
        ld_we = 1'b0;
        ref_mem[idx] = d;
        ref_ok[idx]  = 1'b1;
    endtask

    task automatic run_fetch(input logic [63:0] a, input int stall,
                             input bit wr_same, input logic [31:0] wr_d,
                             input bit drop_ce, input string tag);
        logic        e_err;
        logic [31:0] e_inst;
        logic [31:0] held;
        int          n;
        int          lat;
        bit          ok;
        @(negedge clk);
        ce = 1'b1; addr = a; req_valid = 1'b1; resp_ready = 1'b0;
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk); n++;
        end
        total++;
        if (req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: ready=%b want 1", tag, req_ready_o);
            req_valid = 1'b0;
            return;
        end
        ref_resp(a, e_err, e_inst);
        if (wr_same) begin
            ld_we = 1'b1; ld_addr = a[13:2]; ld_data = wr_d;
        end
        @(posedge clk); #1;
        exp_cnt++;
        req_valid = 1'b0; ld_we = 1'b0;
        if (wr_same) ref_mem[a[13:2]] = wr_d;
        if (drop_ce) ce = 1'b0;
        total++;
        if (req_cnt_o !== exp_cnt || req_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL %s count: cnt=%0d rdy=%b want cnt=%0d rdy=0",
                     tag, req_cnt_o, req_ready_o, exp_cnt);
        end
        lat = 0;
        while (!resp_valid_o && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        total++;
        if (lat != LAT) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, LAT);
        end
        total++;
        if (err_o !== e_err || inst_o !== e_inst) begin
            bad++;
            $display("FAIL %s data: err=%b inst=%h want err=%b inst=%h",
                     tag, err_o, inst_o, e_err, e_inst);
        end
        held = inst_o;
        ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (resp_valid_o !== 1'b1 || inst_o !== held
                || req_ready_o !== 1'b0) ok = 1'b0;
        end
        if (stall > 0) begin
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s stall: v=%b inst=%h rdy=%b want 1 %h 0",
                         tag, resp_valid_o, inst_o, req_ready_o, held);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        total++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== ce) begin
            bad++;
            $display("FAIL %s handshake: v=%b rdy=%b want v=0 rdy=%b",
                     tag, resp_valid_o, req_ready_o, ce);
        end
        ce = 1'b1;
    endtask

    task automatic test_reset;
        #12;
        total++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b0
            || inst_o !== 32'h0 || err_o !== 1'b0 || req_cnt_o !== 32'h0) begin
            bad++;
            $display("FAIL reset: v=%b rdy=%b inst=%h err=%b cnt=%0d want 0s",
                     resp_valid_o, req_ready_o, inst_o, err_o, req_cnt_o);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic;
        load(0, 32'h0000_0413);
        load(1, 32'h0010_0093);
        load(NW - 1, 32'hCAFE_F00D);
        run_fetch(BASE, 0, 1'b0, 32'h0, 1'b0, "basic");
    endtask

    task automatic test_back_to_back;
        run_fetch(BASE, 0, 1'b0, 32'h0, 1'b0, "b2b0");
        run_fetch(BASE + 4, 0, 1'b0, 32'h0, 1'b0, "b2b1");
        run_fetch(BASE + 4 * (NW - 1), 0, 1'b0, 32'h0, 1'b0, "last_word");
    endtask

    task automatic test_stall;
        run_fetch(BASE + 4, 5, 1'b0, 32'h0, 1'b0, "stall");
        run_fetch(BASE, 2, 1'b0, 32'h0, 1'b1, "ce_drop");
    endtask

    task automatic test_fault;
        run_fetch(64'h8000_0002, 0, 1'b0, 32'h0, 1'b0, "misalign");
        run_fetch(64'h7FFF_FFFC, 0, 1'b0, 32'h0, 1'b0, "below");
        run_fetch(64'h8000_4000, 1, 1'b0, 32'h0, 1'b0, "above");
        run_fetch(64'h1_8000_0000, 0, 1'b0, 32'h0, 1'b0, "high64");
    endtask

    task automatic test_raw;
        run_fetch(BASE, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, "rbw_old");
        run_fetch(BASE, 0, 1'b0, 32'h0, 1'b0, "rbw_new");
    endtask

    task automatic test_ce_gate;
        bit ok;
        @(negedge clk);
        ce = 1'b0; req_valid = 1'b1; addr = BASE;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req_ready_o !== 1'b0 || req_cnt_o !== exp_cnt) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ce_gate: rdy=%b cnt=%0d want 0 %0d",
                     req_ready_o, req_cnt_o, exp_cnt);
        end
        req_valid = 1'b0; ce = 1'b1;
    endtask

    task automatic test_reset_mid_wait;
        bit ok;
        @(negedge clk);
        ce = 1'b1; addr = BASE + 4; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        exp_cnt = 0;
        total++;
        if (resp_valid_o !== 1'b0 || req_cnt_o !== 32'h0
            || req_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_wait: v=%b cnt=%0d rdy=%b want 0 0 0",
                     resp_valid_o, req_cnt_o, req_ready_o);
        end
        @(negedge clk);
        rst = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (resp_valid_o !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rst_noresp: resp_valid seen 1 want 0");
        end
        run_fetch(BASE + 4, 0, 1'b0, 32'h0, 1'b0, "post_rst");
    endtask

    task automatic test_random;
        logic [63:0] a;
        int          k;
        int          w;
        for (int i = 0; i < 64; i++) begin
            load(i, $urandom);
        end
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 5);
            w = $urandom_range(0, 63);
            case (k)
                0, 1, 2: a = BASE + 64'(4 * w);
                3:       a = BASE + 64'(4 * w) + 64'($urandom_range(1, 3));
                4:       a = BASE - 64'(4 * $urandom_range(1, 1000));
                default: a = BASE + 64'h4000 + 64'(4 * $urandom_range(0, 999));
            endcase
            if ($urandom_range(0, 3) == 0) load(w, $urandom);
            run_fetch(a, $urandom_range(0, 3),
                      (k < 3) && ($urandom_range(0, 3) == 0), $urandom,
                      $urandom_range(0, 1) == 1, "rand");
        end
    endtask

    initial begin
        total = 0; bad = 0; exp_cnt = 0;
        rst = 1'b0; ce = 1'b1; req_valid = 1'b0; addr = '0;
        resp_ready = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        for (int i = 0; i < NW; i++) begin
            ref_mem[i] = '0;
            ref_ok[i]  = 1'b0;
        end
        test_reset;
        test_basic;
        test_back_to_back;
        test_stall;
        test_fault;
        test_raw;
        test_ce_gate;
        test_reset_mid_wait;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
